rob_tag_allocator: RTL and testbench

- Produces the phase-bit ROB tags that the out-of-order core's age comparisons consume.
- Owns the ROB head and tail pointers, each of width ROB_TAG_WIDTH+1, where the MSB is the phase bit.
- Allocates one tag per dispatch, retires one tag per commit, and rolls the tail back on a branch-mispredict flush.
- Sits between dispatch/rename (allocation), the commit stage (retire) and branch resolution (flush).

---
 rtl/rob_tag_allocator_pkg.sv | 16 +
 rtl/rob_tag_allocator_if.sv | 28 ++
 rtl/rob_age_comparator_with_phase_bit.sv | 20 ++
 rtl/rob_tag_allocator.sv | 101 ++++++++++
 tb/tb_rob_tag_allocator.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/rob_tag_allocator_pkg.sv
// Shared types and helpers for the ROB tag allocator: phase-bit tags and
// their modulo increment.
package rob_tag_allocator_pkg;

  localparam int ROB_TAG_WIDTH = 3;
  localparam int ROB_DEPTH     = 2 ** ROB_TAG_WIDTH;

  // Index in [ROB_TAG_WIDTH-1:0], phase bit in [ROB_TAG_WIDTH].
  typedef logic [ROB_TAG_WIDTH:0] rob_tag_t;

  // Plain binary increment over the full tag; index wrap toggles the phase.
  function automatic rob_tag_t rob_tag_incr(input rob_tag_t tag);
    return tag + rob_tag_t'(1);
  endfunction

endpackage

// File: rtl/rob_tag_allocator_if.sv
// Dispatch / commit / flush signal bundle between the pipeline and the ROB
// tag allocator.
interface rob_tag_allocator_if;
  import rob_tag_allocator_pkg::*;

  logic     alloc_valid;
  logic     alloc_ready;
  rob_tag_t alloc_tag;
  logic     commit_valid;
  rob_tag_t head_tag;
  logic     flush;
  rob_tag_t flush_tag;
  logic     flush_invalid;
  rob_tag_t count;
  logic     empty;
  logic     full;

  modport master (
    output alloc_valid, commit_valid, flush, flush_tag,
    input  alloc_ready, alloc_tag, head_tag, flush_invalid, count, empty, full
  );

  modport slave (
    input  alloc_valid, commit_valid, flush, flush_tag,
    output alloc_ready, alloc_tag, head_tag, flush_invalid, count, empty, full
  );

endinterface

// File: rtl/rob_age_comparator_with_phase_bit.sv
// Age comparison of two in-window ROB tags: equal phases compare indices
// directly, differing phases mean the lower index has already wrapped.
module rob_age_comparator_with_phase_bit
  import rob_tag_allocator_pkg::*;
(
  input  rob_tag_t tag_a,
  input  rob_tag_t tag_b,
  output logic     a_older
);

  logic                     same_phase;
  logic [ROB_TAG_WIDTH-1:0] idx_a;
  logic [ROB_TAG_WIDTH-1:0] idx_b;

  assign same_phase = (tag_a[ROB_TAG_WIDTH] == tag_b[ROB_TAG_WIDTH]);
  assign idx_a      = tag_a[ROB_TAG_WIDTH-1:0];
  assign idx_b      = tag_b[ROB_TAG_WIDTH-1:0];
  assign a_older    = same_phase ? (idx_a < idx_b) : (idx_a > idx_b);

endmodule

// File: rtl/rob_tag_allocator.sv
// ROB head/tail pointer owner: grants phase-bit tags at dispatch, retires at
// commit and rolls the tail back to just past a mispredicted branch.
module rob_tag_allocator
  import rob_tag_allocator_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  rob_tag_allocator_if.slave bus
);

  rob_tag_t head_q;
  rob_tag_t tail_q;
  logic     flush_invalid_q;

  rob_tag_t head_d;
  rob_tag_t tail_d;
  rob_tag_t occupancy;
  rob_tag_t flush_offset;
  logic     empty;
  logic     full;
  logic     alloc_ready;
  logic     alloc_fire;
  logic     commit_fire;
  logic     flush_in_range;
  logic     flush_valid;

  assign empty        = (head_q == tail_q);
  assign full         = (head_q[ROB_TAG_WIDTH-1:0] == tail_q[ROB_TAG_WIDTH-1:0]) &&
                        (head_q[ROB_TAG_WIDTH] != tail_q[ROB_TAG_WIDTH]);
  assign occupancy    = tail_q - head_q;
  assign alloc_ready  = !full && !bus.flush;
  assign alloc_fire   = bus.alloc_valid && alloc_ready;
  assign commit_fire  = bus.commit_valid && !empty;

  // Distance from the oldest entry; the branch survives only if it is in flight.
  assign flush_offset   = bus.flush_tag - head_q;
  assign flush_in_range = (flush_offset < occupancy);
  assign flush_valid    = bus.flush && flush_in_range;

  // NOTE: every always_comb output is given its hold value first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (commit_fire) head_d = rob_tag_incr(head_q);
    if (flush_valid)     tail_d = rob_tag_incr(bus.flush_tag);
    else if (alloc_fire) tail_d = rob_tag_incr(tail_q);
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q          <= '0;
      tail_q          <= '0;
      flush_invalid_q <= 1'b0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      flush_invalid_q <= bus.flush && !flush_in_range;
    end
  end

  assign bus.alloc_ready   = alloc_ready;
  assign bus.alloc_tag     = tail_q;
  assign bus.head_tag      = head_q;
  assign bus.flush_invalid = flush_invalid_q;
  assign bus.count         = occupancy;
  assign bus.empty         = empty;
  assign bus.full          = full;

  // Phase-bit age view of the flush window: head <= flush_tag < tail.
  logic flush_older_than_tail;
  logic flush_older_than_head;
  logic cmp_in_range;

  rob_age_comparator_with_phase_bit u_cmp_flush_tail (
    .tag_a   (bus.flush_tag),
    .tag_b   (tail_q),
    .a_older (flush_older_than_tail)
  );

  rob_age_comparator_with_phase_bit u_cmp_head_flush (
    .tag_a   (bus.flush_tag),
    .tag_b   (head_q),
    .a_older (flush_older_than_head)
  );

  assign cmp_in_range = flush_older_than_tail && !flush_older_than_head;

  // When full, tail aliases head in the phase view, so only count decides there.
  a_flush_range_xcheck: assert property (@(posedge clk) disable iff (reset)
    (bus.flush && !full) |-> (cmp_in_range == flush_in_range));

  a_commit_not_empty: assert property (@(posedge clk) disable iff (reset)
    !(bus.commit_valid && empty));

  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    occupancy <= rob_tag_t'(ROB_DEPTH));

endmodule

// File: tb/tb_rob_tag_allocator.sv
// Directed bench for rob_tag_allocator: a queue model of in-flight tags is
// compared every cycle, plus literal expectations for the key scenarios.
module tb_rob_tag_allocator;
  import rob_tag_allocator_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rob_tag_allocator_if bus ();

  rob_tag_allocator dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: tags currently in flight, oldest first, and the next tag to hand out.
  rob_tag_t q[$];
  rob_tag_t next_tag;
  logic     m_finv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    rob_tag_t mh;
    mh = (q.size() != 0) ? q[0] : next_tag;
    check("cmp.head_tag",      32'(bus.head_tag),      32'(mh));
    check("cmp.alloc_tag",     32'(bus.alloc_tag),     32'(next_tag));
    check("cmp.count",         32'(bus.count),         32'(q.size()));
    check("cmp.empty",         32'(bus.empty),         32'(q.size() == 0));
    check("cmp.full",          32'(bus.full),          32'(q.size() == ROB_DEPTH));
    check("cmp.alloc_ready",   32'(bus.alloc_ready),   32'((q.size() != ROB_DEPTH) && !bus.flush));
    check("cmp.flush_invalid", 32'(bus.flush_invalid), 32'(m_finv));
  endtask

  task automatic model_step();
    int found;
    bit pre_full;
    bit pre_nonempty;
    bit fire;
    found        = -1;
    pre_full     = (q.size() == ROB_DEPTH);
    pre_nonempty = (q.size() != 0);
    if (reset) begin
      q.delete();
      next_tag = '0;
      m_finv   = 1'b0;
      return;
    end
    fire = bus.alloc_valid && !pre_full && !bus.flush;
    if (bus.flush) foreach (q[k]) if (q[k] == bus.flush_tag) found = k;
    m_finv = bus.flush && (found < 0);
    if (found >= 0) begin
      while (q.size() > found + 1) void'(q.pop_back());
      next_tag = rob_tag_t'(bus.flush_tag + rob_tag_t'(1));
    end
    if (bus.commit_valid && pre_nonempty) void'(q.pop_front());
    if (fire) begin
      q.push_back(next_tag);
      next_tag = rob_tag_t'(next_tag + rob_tag_t'(1));
    end
  endtask

  task automatic drive(input logic av, input logic cv, input logic fl, input rob_tag_t ft);
    bus.alloc_valid  = av;
    bus.commit_valid = cv;
    bus.flush        = fl;
    bus.flush_tag    = ft;
  endtask

  // Compare mid-cycle, advance the model, then land just after the edge.
  task automatic step();
    @(negedge clk);
    compare_model();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic av, input logic cv, input logic fl, input rob_tag_t ft);
    drive(av, cv, fl, ft);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    q.delete();
    next_tag = '0;
    m_finv   = 1'b0;
    reset    = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state.
    check("rst.head_tag",    32'(bus.head_tag),    32'h0);
    check("rst.alloc_tag",   32'(bus.alloc_tag),   32'h0);
    check("rst.empty",       32'(bus.empty),       32'h1);
    check("rst.full",        32'(bus.full),        32'h0);
    check("rst.count",       32'(bus.count),       32'h0);
    check("rst.alloc_ready", 32'(bus.alloc_ready), 32'h1);
    tick(1'b0, 1'b0, 1'b0, 4'h0);

    // Fill: tags 0..7 in order.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b0, 4'h0);
      #1;
      check("fill.alloc_tag", 32'(bus.alloc_tag), 32'(i));
      step();
    end
    check("fill.full",        32'(bus.full),        32'h1);
    check("fill.count",       32'(bus.count),       32'h8);
    check("fill.alloc_ready", 32'(bus.alloc_ready), 32'h0);
    check("fill.alloc_tag8",  32'(bus.alloc_tag),   32'h8);

    // A ninth request is refused.
    tick(1'b1, 1'b0, 1'b0, 4'h0);
    check("ninth.alloc_tag", 32'(bus.alloc_tag), 32'h8);
    check("ninth.count",     32'(bus.count),     32'h8);

    // Full: alloc and commit together, no bypass.
    tick(1'b1, 1'b1, 1'b0, 4'h0);
    check("nobyp.head_tag",  32'(bus.head_tag),  32'h1);
    check("nobyp.alloc_tag", 32'(bus.alloc_tag), 32'h8);
    check("nobyp.count",     32'(bus.count),     32'h7);
    drive(1'b1, 1'b0, 1'b0, 4'h0);
    #1;
    check("wrap.grant8",     32'(bus.alloc_tag), 32'h8);
    step();
    check("wrap.alloc_tag9", 32'(bus.alloc_tag), 32'h9);
    check("wrap.full",       32'(bus.full),      32'h1);

    // Move to head=6, tail=B.
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, 1'b0, 4'h0);
    check("setup.head_tag",  32'(bus.head_tag),  32'h6);
    check("setup.alloc_tag", 32'(bus.alloc_tag), 32'hB);
    check("setup.count",     32'(bus.count),     32'h5);

    // Valid flush at 8: tail rolls back to 9, allocation blocked that cycle.
    drive(1'b1, 1'b0, 1'b1, 4'h8);
    #1;
    check("vflush.alloc_ready", 32'(bus.alloc_ready), 32'h0);
    step();
    check("vflush.alloc_tag",     32'(bus.alloc_tag),     32'h9);
    check("vflush.count",         32'(bus.count),         32'h3);
    check("vflush.flush_invalid", 32'(bus.flush_invalid), 32'h0);

    // Invalid flush at C (younger than tail B).
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, 1'b0, 4'h0);
    tick(1'b0, 1'b0, 1'b1, 4'hC);
    check("iflush.alloc_tag",     32'(bus.alloc_tag),     32'hB);
    check("iflush.count",         32'(bus.count),         32'h5);
    check("iflush.flush_invalid", 32'(bus.flush_invalid), 32'h1);
    tick(1'b0, 1'b0, 1'b0, 4'h0);
    check("iflush.pulse_end",     32'(bus.flush_invalid), 32'h0);

    // Flush at head plus commit: drains to empty at head+1.
    tick(1'b0, 1'b1, 1'b1, 4'h6);
    check("fhead.empty",     32'(bus.empty),     32'h1);
    check("fhead.head_tag",  32'(bus.head_tag),  32'h7);
    check("fhead.alloc_tag", 32'(bus.alloc_tag), 32'h7);
    check("fhead.count",     32'(bus.count),     32'h0);

    // Mixed traffic across several phase wraps, checked by the model only.
    for (int i = 0; i < 48; i++) begin
      logic     av;
      logic     cv;
      logic     fl;
      rob_tag_t ft;
      av = ((i % 3) != 2);
      cv = ((i % 4) != 0) && (q.size() != 0);
      fl = ((i % 11) == 5) || ((i % 13) == 9);
      if (q.size() != 0 && (i % 2) == 1) ft = q[q.size() / 2];
      else                               ft = rob_tag_t'(next_tag + rob_tag_t'(3));
      tick(av, cv, fl, ft);
    end

    // Reset mid-stream with every operation active.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 4'h0);
    reset = 1'b1;
    tick(1'b1, 1'b1, 1'b1, q[0]);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    #1;
    check("mrst.head_tag",      32'(bus.head_tag),      32'h0);
    check("mrst.alloc_tag",     32'(bus.alloc_tag),     32'h0);
    check("mrst.empty",         32'(bus.empty),         32'h1);
    check("mrst.full",          32'(bus.full),          32'h0);
    check("mrst.count",         32'(bus.count),         32'h0);
    check("mrst.alloc_ready",   32'(bus.alloc_ready),   32'h1);
    check("mrst.flush_invalid", 32'(bus.flush_invalid), 32'h0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 4'h0);
    check("post.alloc_tag", 32'(bus.alloc_tag), 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
